// File: rtl/high_score_writer_if.sv
// Memory port bundle between high_score_writer (master) and the game's
// 16x8 Memory instance (slave): one registered read port, one write port.
interface high_score_writer_if;
  logic       Mem_R_En;
  logic [3:0] Mem_R_Addr;
  logic [7:0] Mem_R_Data;
  logic       Mem_W_En;
  logic [3:0] Mem_W_Addr;
  logic [7:0] Mem_W_Data;

  modport master (
    output Mem_R_En,
    output Mem_R_Addr,
    input  Mem_R_Data,
    output Mem_W_En,
    output Mem_W_Addr,
    output Mem_W_Data
  );

  modport slave (
    input  Mem_R_En,
    input  Mem_R_Addr,
    output Mem_R_Data,
    input  Mem_W_En,
    input  Mem_W_Addr,
    input  Mem_W_Data
  );
endinterface

// File: rtl/high_score_writer.sv
// high_score_writer: on each game-over pulse, reads the best score stored at
// BEST_ADDR, writes the final score back if it is strictly higher, and keeps
// o_Best_Score up to date. Define HIGH_SCORE_LOG_EN to also append every
// final score to a circular history log at LOG_BASE..LOG_BASE+LOG_DEPTH-1.
// The pulse is latched at E0 and the read goes out at E1, so the memory read
// data (valid one clock after the read enable) is captured on the WAIT exit.
module high_score_writer #(
  parameter int         SCORE_BITS = 6,
  parameter logic [3:0] BEST_ADDR  = 4'd0,
  parameter logic [3:0] LOG_BASE   = 4'd1,
  parameter int         LOG_DEPTH  = 15
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_Game_Over,
  input  logic [SCORE_BITS-1:0] i_Score,
  high_score_writer_if.master   Mem,
  output logic                  o_Busy,
  output logic                  o_New_Record,
  output logic [SCORE_BITS-1:0] o_Best_Score
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_CMP,
    S_WR_BEST
`ifdef HIGH_SCORE_LOG_EN
    , S_LOG
`endif
  } state_t;

  state_t                r_State;
  logic                  r_Start;
  logic [SCORE_BITS-1:0] r_Score;
  logic [SCORE_BITS-1:0] r_Old;
  logic [7:0]            w_Score_Byte;

  assign w_Score_Byte = 8'(r_Score);

`ifdef HIGH_SCORE_LOG_EN
  localparam logic [3:0] PTR_LAST = 4'(LOG_DEPTH - 1);

  logic [3:0] r_Ptr;
  logic [3:0] w_Log_Addr;
  logic       w_unused;

  assign w_Log_Addr = LOG_BASE + r_Ptr;
  // Upper stored bits are ignored by design.
  assign w_unused   = &{1'b0, Mem.Mem_R_Data[7:SCORE_BITS]};
`else
  logic w_unused;

  // Upper stored bits are ignored and the log geometry has no use without the log.
  assign w_unused = &{1'b0, Mem.Mem_R_Data[7:SCORE_BITS], LOG_BASE, (LOG_DEPTH != 0)};
`endif

  // FSM with registered outputs; each transition also sets the outputs of the state it enters.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State         <= S_IDLE;
      r_Start         <= 1'b0;
      r_Score         <= '0;
      r_Old           <= '0;
`ifdef HIGH_SCORE_LOG_EN
      r_Ptr           <= '0;
`endif
      Mem.Mem_R_En    <= 1'b0;
      Mem.Mem_R_Addr  <= '0;
      Mem.Mem_W_En    <= 1'b0;
      Mem.Mem_W_Addr  <= '0;
      Mem.Mem_W_Data  <= '0;
      o_Busy          <= 1'b0;
      o_New_Record    <= 1'b0;
      o_Best_Score    <= '0;
    end else begin
      r_Start         <= 1'b0;
      Mem.Mem_R_En    <= 1'b0;
      Mem.Mem_W_En    <= 1'b0;
      Mem.Mem_W_Addr  <= '0;
      Mem.Mem_W_Data  <= '0;
      o_New_Record    <= 1'b0;

      case (r_State)
        S_IDLE: begin
          if (r_Start) begin
            r_State        <= S_RD;
            Mem.Mem_R_En   <= 1'b1;
            Mem.Mem_R_Addr <= BEST_ADDR;
            o_Busy         <= 1'b1;
          end else if (i_Game_Over) begin
            r_Score <= i_Score;
            r_Start <= 1'b1;
          end
        end

        S_RD: begin
          r_State <= S_WAIT;
        end

        S_WAIT: begin
          r_Old   <= Mem.Mem_R_Data[SCORE_BITS-1:0];
          r_State <= S_CMP;
        end

        S_CMP: begin
          if (r_Score > r_Old) begin
            r_State        <= S_WR_BEST;
            Mem.Mem_W_En   <= 1'b1;
            Mem.Mem_W_Addr <= BEST_ADDR;
            Mem.Mem_W_Data <= w_Score_Byte;
            o_New_Record   <= 1'b1;
            o_Best_Score   <= r_Score;
          end else begin
            o_Best_Score <= r_Old;
`ifdef HIGH_SCORE_LOG_EN
            r_State        <= S_LOG;
            Mem.Mem_W_En   <= 1'b1;
            Mem.Mem_W_Addr <= w_Log_Addr;
            Mem.Mem_W_Data <= w_Score_Byte;
`else
            r_State <= S_IDLE;
            o_Busy  <= 1'b0;
`endif
          end
        end

        S_WR_BEST: begin
`ifdef HIGH_SCORE_LOG_EN
          r_State        <= S_LOG;
          Mem.Mem_W_En   <= 1'b1;
          Mem.Mem_W_Addr <= w_Log_Addr;
          Mem.Mem_W_Data <= w_Score_Byte;
`else
          r_State <= S_IDLE;
          o_Busy  <= 1'b0;
`endif
        end

`ifdef HIGH_SCORE_LOG_EN
        S_LOG: begin
          r_Ptr   <= (r_Ptr == PTR_LAST) ? 4'd0 : r_Ptr + 4'd1;
          r_State <= S_IDLE;
          o_Busy  <= 1'b0;
        end
`endif

        default: begin
          r_State <= S_IDLE;
          o_Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_high_score_writer.sv
// Self-checking bench for high_score_writer: a small memory model serves the
// read port, a scoreboard queue holds the writes each game-over should cause,
// and directed steps check the transaction schedule and outputs.
module tb_high_score_writer;

  localparam int SB = 6;
`ifdef HIGH_SCORE_LOG_EN
  localparam bit LogEn = 1'b1;
`else
  localparam bit LogEn = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rstN;
  logic          gameOver;
  logic [SB-1:0] scoreIn;
  logic          busy;
  logic          newRecord;
  logic [SB-1:0] bestScore;

  logic [7:0]    memArray [16];
  logic          preloadReq;
  logic [7:0]    preloadVal;

  wr_t           expQ [$];
  wr_t           expWr;
  int            vectors = 0;
  int            miscompares = 0;
  logic [7:0]    modelBest;
  int            modelPtr;

  high_score_writer_if memBus ();

  high_score_writer dut (
    .i_Clk        (clk),
    .i_Rst_L      (rstN),
    .i_Game_Over  (gameOver),
    .i_Score      (scoreIn),
    .Mem          (memBus),
    .o_Busy       (busy),
    .o_New_Record (newRecord),
    .o_Best_Score (bestScore)
  );

  always #5 clk = ~clk;

  // Memory model: registered read, write on the clock edge, bench preload of address 0.
  always @(posedge clk) begin
    if (memBus.Mem_W_En) memArray[memBus.Mem_W_Addr] <= memBus.Mem_W_Data;
    if (preloadReq) memArray[0] <= preloadVal;
    if (memBus.Mem_R_En) memBus.Mem_R_Data <= memArray[memBus.Mem_R_Addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Write monitor: every write must match the scoreboard head; reads and writes never overlap.
  always @(negedge clk) begin
    if (memBus.Mem_R_En === 1'b1 || memBus.Mem_W_En === 1'b1)
      checkOutput("rdWrExclusive", {31'b0, memBus.Mem_R_En & memBus.Mem_W_En}, 32'd0);
    if (memBus.Mem_W_En === 1'b1) begin
      vectors++;
      assert (expQ.size() != 0)
      else begin
        miscompares++;
        $error("[TB] FAIL unexpectedWrite observed addr=%0h data=%0h expected no write",
               memBus.Mem_W_Addr, memBus.Mem_W_Data);
      end
      if (expQ.size() != 0) begin
        expWr = expQ.pop_front();
        checkOutput("wrAddr", {28'b0, memBus.Mem_W_Addr}, {28'b0, expWr.addr});
        checkOutput("wrData", {24'b0, memBus.Mem_W_Data}, {24'b0, expWr.data});
      end
    end
  end

  task automatic setBest(input logic [7:0] v);
    @(negedge clk);
    preloadVal = v;
    preloadReq = 1'b1;
    @(negedge clk);
    preloadReq = 1'b0;
    modelBest  = v;
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, "_busy"},      {31'b0, busy}, 32'd0);
    checkOutput({phase, "_newRecord"}, {31'b0, newRecord}, 32'd0);
    checkOutput({phase, "_bestScore"}, {26'b0, bestScore}, 32'd0);
    checkOutput({phase, "_rdEn"},      {31'b0, memBus.Mem_R_En}, 32'd0);
    checkOutput({phase, "_rdAddr"},    {28'b0, memBus.Mem_R_Addr}, 32'd0);
    checkOutput({phase, "_wrEn"},      {31'b0, memBus.Mem_W_En}, 32'd0);
    checkOutput({phase, "_wrAddr"},    {28'b0, memBus.Mem_W_Addr}, 32'd0);
    checkOutput({phase, "_wrData"},    {24'b0, memBus.Mem_W_Data}, 32'd0);
  endtask

  // One game-over transaction; dropScore != 0 fires a second pulse at E2 that must be ignored.
  task automatic applyStimulus(input logic [SB-1:0] score, input logic [SB-1:0] dropScore);
    logic          rec;
    int            cycles;
    int            expCycles;
    logic [SB-1:0] expBest;

    rec = (score > modelBest[SB-1:0]);
    if (rec) expQ.push_back({4'd0, 8'(score)});
    if (LogEn) begin
      expQ.push_back({4'(1 + modelPtr), 8'(score)});
      modelPtr = (modelPtr == 14) ? 0 : modelPtr + 1;
    end
    expBest   = rec ? score : modelBest[SB-1:0];
    if (rec) modelBest = 8'(score);
    expCycles = (LogEn ? 5 : 4) + (rec ? 1 : 0);

    @(negedge clk);
    gameOver = 1'b1;
    scoreIn  = score;
    @(posedge clk);
    #1;
    gameOver = 1'b0;
    checkOutput("busyAtE0", {31'b0, busy}, 32'd0);

    @(posedge clk);
    #1;
    cycles = 1;
    checkOutput("busyAtE1",   {31'b0, busy}, 32'd1);
    checkOutput("rdEnAtE1",   {31'b0, memBus.Mem_R_En}, 32'd1);
    checkOutput("rdAddrAtE1", {28'b0, memBus.Mem_R_Addr}, 32'd0);

    do begin
      if (cycles == 1 && dropScore != 0) begin
        gameOver = 1'b1;
        scoreIn  = dropScore;
      end
      @(posedge clk);
      #1;
      gameOver = 1'b0;
      cycles++;
      if (cycles == 4) checkOutput("newRecordAtE4", {31'b0, newRecord}, {31'b0, rec});
      if (cycles == 5) checkOutput("newRecordAtE5", {31'b0, newRecord}, 32'd0);
    end while (busy && cycles < 20);

    checkOutput("idleEdge",  cycles, expCycles);
    checkOutput("bestScore", {26'b0, bestScore}, {26'b0, expBest});
  endtask

  initial begin
    rstN       = 1'b0;
    gameOver   = 1'b0;
    scoreIn    = '0;
    preloadReq = 1'b0;
    preloadVal = '0;
    modelBest  = '0;
    modelPtr   = 0;

    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] best-score update");
    setBest(8'h05);
    applyStimulus(6'd9, 6'd0);

    $display("[TB] equal score is not a record");
    setBest(8'h0C);
    applyStimulus(6'd12, 6'd0);

    $display("[TB] upper stored bits ignored");
    setBest(8'hC2);
    applyStimulus(6'd5, 6'd0);

    $display("[TB] pulse while busy is dropped");
    setBest(8'h05);
    applyStimulus(6'd20, 6'd40);

    $display("[TB] reset during best-score write");
    setBest(8'h00);
    expQ.push_back({4'd0, 8'd33});
    @(negedge clk);
    gameOver = 1'b1;
    scoreIn  = 6'd33;
    @(posedge clk);
    #1;
    gameOver = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("wrBestActive", {31'b0, memBus.Mem_W_En}, 32'd1);
    @(negedge clk);
    #1;
    rstN = 1'b0;
    #1;
    checkResetOutputs("midReset");
    repeat (2) @(negedge clk);
    rstN      = 1'b1;
    modelPtr  = 0;
    modelBest = 8'h00;
    setBest(8'h00);
    applyStimulus(6'd3, 6'd0);

    $display("[TB] log sequence with wrap");
    setBest(8'h3F);
    for (int i = 1; i <= 16; i++) applyStimulus(6'(i), 6'd0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queueDrained", expQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/high_score_writer.md
# high_score_writer

Write-side client for the game's 16×8 `Memory` instance. It drives the `w_en/w_addr/w_data` port, which the game top otherwise leaves unused. On each game-over event it reads the stored best score at address 0, compares it with the final score, and writes back a new record if the final score is higher. Optionally it appends every final score to a circular history log at addresses 1..15. It sits beside `Character_Control` and `Memory` in the top level, and the top arbitrates the shared read port with `o_Mem_R_En`.

## Interface
Parameters:
- `SCORE_BITS`, 6: width of the score bus; matches `o_Score` of `Character_Control`.
- `BEST_ADDR`, 4'd0: memory address of the best score.
- `LOG_BASE`, 4'd1: first history address.
- `LOG_DEPTH`, 15: number of history entries, occupying addresses `LOG_BASE` to `LOG_BASE+LOG_DEPTH-1`.

Ports:
- `i_Clk`  in  1  system clock.
- `i_Rst_L`  in  1  reset; asynchronous, active-low.
- `i_Game_Over`  in  1  single-cycle pulse; RUNNING→IDLE transition caused by a collision.
- `i_Score`  in  `SCORE_BITS`  final score; valid in the same cycle as `i_Game_Over`.
- `o_Mem_R_En`  out  1  memory read enable.
- `o_Mem_R_Addr`  out  4  memory read address.
- `i_Mem_R_Data`  in  8  memory read data; registered, valid one clock after the `o_Mem_R_En` edge.
- `o_Mem_W_En`  out  1  memory write enable.
- `o_Mem_W_Addr`  out  4  memory write address.
- `o_Mem_W_Data`  out  8  memory write data.
- `o_Busy`  out  1  high in every state except IDLE.
- `o_New_Record`  out  1  one-cycle pulse when a new best score is written.
- `o_Best_Score`  out  `SCORE_BITS`  last known best score.

## Operation
- State machine:
  - **IDLE**: when `i_Game_Over`=1, latch `i_Score` into `r_Score` and go to RD.
  - **RD**: `o_Mem_R_En`=1, `o_Mem_R_Addr`=`BEST_ADDR`; go to WAIT.
  - **WAIT**: capture `i_Mem_R_Data[SCORE_BITS-1:0]` into `r_Old`; go to CMP.
  - **CMP**: if `r_Score > r_Old`, go to WR_BEST. Otherwise load `o_Best_Score`←`r_Old`, then go to LOG if the log is compiled in, else IDLE.
  - **WR_BEST**: `o_Mem_W_En`=1, address `BEST_ADDR`, data zero-extended `r_Score`. Pulse `o_New_Record`. Set `o_Best_Score`←`r_Score`. Go to LOG or IDLE.
  - **LOG**: `o_Mem_W_En`=1, address `LOG_BASE+r_Ptr`, data zero-extended `r_Score`. Increment `r_Ptr`, wrapping from `LOG_DEPTH-1` to 0. Go to IDLE.
- Comparison rules:
  - The comparison is unsigned and strict; equal scores are not records.
  - Bits [7:SCORE_BITS] of the stored byte are ignored on read and written as 0.
- Edge cases:
  - `i_Game_Over` while `o_Busy`=1 is dropped. There is no queueing and `r_Score` is not overwritten.
  - `i_Game_Over` in the same cycle the FSM returns to IDLE is accepted on the next edge only if it is still high; the block has no pulse stretching.
- Reset: when `i_Rst_L` falls, the FSM goes to IDLE immediately, including mid-write. An interrupted write may or may not have committed; the block does not retry it.
- Read and write enables are never asserted in the same cycle.

## Timing
- Reset values:
  - All outputs 0, with `o_Mem_R_Addr`/`o_Mem_W_Addr` = 0.
  - `r_Ptr` = 0, `r_Score` = 0, `r_Old` = 0.
- Outputs are registered, decoded from state.
- With the pulse sampled at edge E0, the FSM follows this schedule:

| Edge | Event |
|---|---|
| E0 | pulse sampled |
| E1 | RD: read enable asserted |
| E2 | WAIT: data captured |
| E3 | CMP |
| E4 | WR_BEST, or LOG if no record |
| E5 | LOG after WR_BEST |

- Return to IDLE:
  - With logging: 5 cycles after E0 without a record, 6 with a record.
  - Without logging: 4 cycles without a record, 5 with a record.
- `o_Busy` rises at E1 and falls at the edge entering IDLE.

## Configuration
- `HIGH_SCORE_LOG_EN` defined:
  - The LOG state, `r_Ptr`, and history writes are compiled in.
  - Every accepted game-over produces exactly one log write.
- `HIGH_SCORE_LOG_EN` undefined:
  - The LOG state and pointer are removed, and addresses `LOG_BASE` and above are never written.
  - CMP and WR_BEST go directly to IDLE.

## Test plan
- Best-score update: memory[0]=0x05, pulse with score=9 → read addr 0 at E1; write addr 0 data 0x09 at E4; `o_New_Record` high one cycle; `o_Best_Score`=9.
- Non-record with log (`HIGH_SCORE_LOG_EN`): memory[0]=0x0C, pulse with score=12 → no write to addr 0 and no `o_New_Record`; log write addr 1 data 0x0C; `o_Best_Score`=12.
- Log wrap (`HIGH_SCORE_LOG_EN`): 16 game-overs with scores 1..16 → writes go to addrs 1..15, then addr 1 again with data 16.
- Dropped pulse: second `i_Game_Over` with score=40 at E2 of a transaction → ignored; only the first score is written; `o_Busy` falls on schedule.
- Mid-write reset: assert `i_Rst_L`=0 during WR_BEST → outputs 0 and state IDLE asynchronously; after release, a pulse with score=3 runs a full transaction from addr `LOG_BASE` (`r_Ptr`=0).
- Upper-bit masking: memory[0]=0xC2, pulse with score=5 → treated as stored 2; write 0x05 to addr 0.
